// File: rtl/jbr_pkg.sv
// Shared types and width helpers for the jump/branch issue queue.
// Widths are functions of rename bits (RB) and datapath width (XLEN).
package jbr_pkg;

  typedef enum logic [1:0] {
    OP_JAL    = 2'd0,
    OP_JALR   = 2'd1,
    OP_BRANCH = 2'd2,
    OP_ILL    = 2'd3
  } jbr_op_e;

  function automatic int jbr_tw(input int rb);
    return 5 + rb;
  endfunction

  // {op, funct3, rd, rs1, rs2, pc, imm, is_rvc}
  function automatic int jbr_info_dw(input int rb, input int xlen);
    return 2 + 3 + 3 * jbr_tw(rb) + 2 * xlen + 1;
  endfunction

  // {op, funct3, rd, src1, src2, pc, imm, is_rvc}
  function automatic int jbr_exe_dw(input int rb, input int xlen);
    return 2 + 3 + jbr_tw(rb) + 4 * xlen + 1;
  endfunction

  // LSB offsets of the dispatch info fields
  function automatic int jbr_info_imm_lsb();
    return 1;
  endfunction

  function automatic int jbr_info_pc_lsb(input int xlen);
    return xlen + 1;
  endfunction

  function automatic int jbr_info_rs2_lsb(input int xlen);
    return 2 * xlen + 1;
  endfunction

  function automatic int jbr_info_rs1_lsb(input int rb, input int xlen);
    return 2 * xlen + 1 + jbr_tw(rb);
  endfunction

  function automatic int jbr_info_rd_lsb(input int rb, input int xlen);
    return 2 * xlen + 1 + 2 * jbr_tw(rb);
  endfunction

  function automatic int jbr_info_op_lsb(input int rb, input int xlen);
    return 2 * xlen + 4 + 3 * jbr_tw(rb);
  endfunction

  localparam int JBR_RB_DEF   = 2;
  localparam int JBR_XLEN_DEF = 64;
  localparam int JBR_TW_DEF   = 5 + JBR_RB_DEF;
  localparam int JBR_INFO_DW  = jbr_info_dw(JBR_RB_DEF, JBR_XLEN_DEF);
  localparam int JBR_EXE_DW   = jbr_exe_dw(JBR_RB_DEF, JBR_XLEN_DEF);

  typedef struct packed {
    logic [1:0]              op;
    logic [2:0]              funct3;
    logic [JBR_TW_DEF-1:0]   rd;
    logic [JBR_TW_DEF-1:0]   rs1;
    logic [JBR_TW_DEF-1:0]   rs2;
    logic [JBR_XLEN_DEF-1:0] pc;
    logic [JBR_XLEN_DEF-1:0] imm;
    logic                    is_rvc;
  } jbr_info_t;

  typedef struct packed {
    logic [1:0]              op;
    logic [2:0]              funct3;
    logic [JBR_TW_DEF-1:0]   rd;
    logic [JBR_XLEN_DEF-1:0] src1;
    logic [JBR_XLEN_DEF-1:0] src2;
    logic [JBR_XLEN_DEF-1:0] pc;
    logic [JBR_XLEN_DEF-1:0] imm;
    logic                    is_rvc;
  } jbr_exe_t;

endpackage

// File: rtl/age_mtx.sv
// Age matrix: older_q[i][j] set means entry j was allocated before entry i.
// Grants the single requesting entry that has no older requester.
module age_mtx #(
  parameter int DP = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic [DP-1:0] valid,
  input  logic [DP-1:0] alloc_oh,
  input  logic [DP-1:0] free_mask,
  input  logic [DP-1:0] req,
  output logic [DP-1:0] gnt
);

  logic [DP-1:0] older_q [DP];
  logic [DP-1:0] older_d [DP];

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      logic [DP-1:0] self;
      self       = '0;
      self[i]    = 1'b1;
      older_d[i] = older_q[i] & ~free_mask;
      // A new entry is younger than everything still resident
      if (alloc_oh[i]) older_d[i] = valid & ~free_mask & ~self;
      if (clr) older_d[i] = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      gnt[i] = req[i] & ~|(older_q[i] & req);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DP; i++) older_q[i] <= '0;
    end else begin
      for (int i = 0; i < DP; i++) older_q[i] <= older_d[i];
    end
  end

endmodule

// File: rtl/jbr_issue.sv
// Jump/branch issue queue: buffers JAL/JALR/BRANCH ops, wakes them on PRF
// writeback and issues the oldest ready one into a valid/ready output register.
module jbr_issue
  import jbr_pkg::*;
#(
  parameter int   DP      = 4,
  parameter int   RB      = 2,
  parameter int   XLEN    = 64,
  localparam int  TW      = 5 + RB,
  localparam int  PRF     = 32 << RB,
  localparam int  INFO_DW = jbr_info_dw(RB, XLEN),
  localparam int  EXE_DW  = jbr_exe_dw(RB, XLEN),
  localparam int  CW      = $clog2(DP + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 disp_valid,
  output logic                 disp_ready,
  input  logic [INFO_DW-1:0]   disp_info,
  input  logic [PRF-1:0]       wbLog_qout,
  input  logic [XLEN*PRF-1:0]  regFileX_read,
  output logic                 exe_valid,
  input  logic                 exe_ready,
  output logic [EXE_DW-1:0]    exe_param,
  output logic [CW-1:0]        occupancy
);

  typedef struct packed {
    logic [1:0]      op;
    logic [2:0]      funct3;
    logic [TW-1:0]   rd;
    logic [TW-1:0]   rs1;
    logic [TW-1:0]   rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            is_rvc;
  } info_t;

  typedef struct packed {
    logic [1:0]      op;
    logic [2:0]      funct3;
    logic [TW-1:0]   rd;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            is_rvc;
  } exe_t;

  info_t         ent_q [DP];
  info_t         ent_d [DP];
  logic [DP-1:0] valid_q, valid_d;
  logic          exe_valid_q, exe_valid_d;
  exe_t          exe_q, exe_d;
  logic [CW-1:0] occ_q, occ_d;

  logic [XLEN-1:0] prf [PRF];
  info_t           in_info;
  info_t           sel;
  logic [DP-1:0]   rdy, req, gnt, free_oh, alloc_oh, free_mask;
  logic            adv, has_cand, issue, alloc;

  for (genvar g = 0; g < PRF; g++) begin : g_prf
    assign prf[g] = regFileX_read[g*XLEN +: XLEN];
  end

  assign in_info    = info_t'(disp_info);
  assign disp_ready = ~&valid_q;
  assign adv        = ~exe_valid_q | exe_ready;
  assign has_cand   = |req;
  assign issue      = adv & has_cand;
  assign alloc      = disp_valid & disp_ready & ~flush;
  assign free_mask  = issue ? gnt : '0;
  assign alloc_oh   = (alloc && in_info.op != OP_ILL) ? free_oh : '0;

  // Same-cycle wakeup straight from the writeback log
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      case (ent_q[i].op)
        OP_JAL:    rdy[i] = 1'b1;
        OP_JALR:   rdy[i] = wbLog_qout[ent_q[i].rs1];
        OP_BRANCH: rdy[i] = wbLog_qout[ent_q[i].rs1] & wbLog_qout[ent_q[i].rs2];
        default:   rdy[i] = 1'b0;
      endcase
    end
    req = valid_q & rdy;
  end

  age_mtx #(.DP(DP)) u_age (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (flush),
    .valid     (valid_q),
    .alloc_oh  (alloc_oh),
    .free_mask (free_mask),
    .req       (req),
    .gnt       (gnt)
  );

  always_comb begin
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DP; i++) begin
      if (!valid_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < DP; i++) begin
      if (gnt[i]) sel = info_t'(sel | ent_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      ent_d[i] = ent_q[i];
      if (disp_valid && free_oh[i]) ent_d[i] = in_info;
    end
    valid_d = flush ? '0 : ((valid_q & ~free_mask) | alloc_oh);
    occ_d   = '0;
    for (int i = 0; i < DP; i++) occ_d = occ_d + CW'(valid_d[i]);
  end

  always_comb begin
    exe_valid_d = exe_valid_q;
    exe_d       = exe_q;
    if (flush) begin
      exe_valid_d = 1'b0;
    end else if (adv) begin
      exe_valid_d = has_cand;
      if (has_cand) begin
        exe_d.op     = sel.op;
        exe_d.funct3 = sel.funct3;
        exe_d.rd     = sel.rd;
        exe_d.src1   = prf[sel.rs1];
        exe_d.src2   = (sel.op == OP_BRANCH) ? prf[sel.rs2] : '0;
        exe_d.pc     = sel.pc;
        exe_d.imm    = sel.imm;
        exe_d.is_rvc = sel.is_rvc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    ent_q <= ent_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= '0;
      exe_valid_q <= 1'b0;
      exe_q       <= '0;
      occ_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      exe_valid_q <= exe_valid_d;
      exe_q       <= exe_d;
      occ_q       <= occ_d;
    end
  end

  assign exe_valid = exe_valid_q;
  assign exe_param = exe_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_jbr_issue.sv
// Bench for jbr_issue: directed dispatch sequences, expected issues queued
// in order and checked by an independent monitor at each handshake.
module tb_jbr_issue;

  localparam int DP = 4, RB = 2, XLEN = 64, TW = 7, PRF = 128;
  localparam int INFO_DW = 155, EXE_DW = 269, CW = 3;

  logic                CLK = 1'b0;
  logic                RST, flush, disp_valid, disp_ready, exe_valid, exe_ready;
  logic [INFO_DW-1:0]  disp_info;
  logic [PRF-1:0]      wb;
  logic [XLEN*PRF-1:0] rf;
  logic [EXE_DW-1:0]   exe_param;
  logic [CW-1:0]       occupancy;

  int checks = 0;
  int errors = 0;
  logic [EXE_DW-1:0] exp_q [$];
  int                id_q  [$];
  logic [EXE_DW-1:0] e0;

  jbr_issue #(.DP(DP), .RB(RB), .XLEN(XLEN)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .flush         (flush),
    .disp_valid    (disp_valid),
    .disp_ready    (disp_ready),
    .disp_info     (disp_info),
    .wbLog_qout    (wb),
    .regFileX_read (rf),
    .exe_valid     (exe_valid),
    .exe_ready     (exe_ready),
    .exe_param     (exe_param),
    .occupancy     (occupancy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [INFO_DW-1:0] info(input logic [1:0] op, input logic [2:0] f3,
      input logic [TW-1:0] rd, input logic [TW-1:0] rs1, input logic [TW-1:0] rs2,
      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic rvc);
    return {op, f3, rd, rs1, rs2, pc, imm, rvc};
  endfunction

  function automatic logic [EXE_DW-1:0] exe(input logic [1:0] op, input logic [2:0] f3,
      input logic [TW-1:0] rd, input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm, input logic rvc);
    return {op, f3, rd, s1, s2, pc, imm, rvc};
  endfunction

  task automatic check(input string name, input logic [EXE_DW-1:0] act,
                       input logic [EXE_DW-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_issue(input logic [EXE_DW-1:0] e, input int id);
    exp_q.push_back(e);
    id_q.push_back(id);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp(input logic [INFO_DW-1:0] i);
    disp_info  = i;
    disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d issues still pending, want 0", name, exp_q.size());
      exp_q.delete();
      id_q.delete();
    end
  endtask

  task automatic set_reg(input int idx, input logic [XLEN-1:0] v);
    rf[idx*XLEN +: XLEN] = v;
  endtask

  // Monitor: a handshake at the coming edge consumes the oldest expectation
  always @(negedge CLK) begin
    if (exe_valid === 1'b1 && exe_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h want none", exe_param);
      end else begin
        check($sformatf("issue_%0d", id_q[0]), exe_param, exp_q[0]);
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_info = '0;
    exe_ready = 1'b1; wb = '1; rf = '0;
    for (int i = 1; i < PRF; i++) set_reg(i, 64'h1000 + 64'(i));
    repeat (3) step();
    RST = 1'b0;
    @(negedge CLK);
    check("rst_exe_valid", exe_valid, 0);
    check("rst_exe_param", exe_param, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_occupancy", occupancy, 0);
    step();

    // single JAL from idle
    expect_issue(exe(2'd0, 3'd0, 7'd5, 64'h0, 64'h0, 64'h8000_0000, 64'h10, 1'b0), 1);
    disp(info(2'd0, 3'd0, 7'd5, 7'd0, 7'd0, 64'h8000_0000, 64'h10, 1'b0));
    wait_drain(10, "t1_drain");
    check("t1_occupancy", occupancy, 0);

    // illegal op is accepted but never occupies an entry
    disp(info(2'd3, 3'd0, 7'd1, 7'd0, 7'd0, 64'h9000, 64'h0, 1'b0));
    repeat (3) step();
    check("ill_occupancy", occupancy, 0);
    check("ill_exe_valid", exe_valid, 0);

    // BRANCH blocked on rs2, younger JAL overtakes
    wb[7] = 1'b0;
    set_reg(7, 64'h77);
    expect_issue(exe(2'd0, 3'd0, 7'd1, 64'h0, 64'h0, 64'h100, 64'h8, 1'b1), 2);
    expect_issue(exe(2'd2, 3'd1, 7'd0, 64'h1003, 64'h55, 64'h200, 64'h40, 1'b0), 3);
    disp(info(2'd2, 3'd1, 7'd0, 7'd3, 7'd7, 64'h200, 64'h40, 1'b0));
    disp(info(2'd0, 3'd0, 7'd1, 7'd0, 7'd0, 64'h100, 64'h8, 1'b1));
    repeat (4) step();
    check("t2_branch_waits", exp_q.size(), 1);
    set_reg(7, 64'h55);
    wb[7] = 1'b1;
    wait_drain(5, "t2_drain");

    // age order across recycled slots
    wb[9] = 1'b0; wb[10] = 1'b0; wb[11] = 1'b0; wb[12] = 1'b0; wb[13] = 1'b0;
    disp(info(2'd1, 3'd0, 7'd1, 7'd11, 7'd0, 64'h300, 64'h0, 1'b0));
    disp(info(2'd1, 3'd0, 7'd1, 7'd13, 7'd0, 64'h304, 64'h0, 1'b0));
    disp(info(2'd1, 3'd0, 7'd1, 7'd12, 7'd0, 64'h308, 64'h0, 1'b0));
    disp(info(2'd1, 3'd0, 7'd1, 7'd10, 7'd0, 64'h30c, 64'h0, 1'b0));
    check("t3_full_ready", disp_ready, 0);
    check("t3_full_occ", occupancy, 4);
    expect_issue(exe(2'd1, 3'd0, 7'd1, 64'h100c, 64'h0, 64'h308, 64'h0, 1'b0), 10);
    wb[12] = 1'b1;
    wait_drain(5, "t3_r");
    disp(info(2'd1, 3'd0, 7'd2, 7'd9, 7'd0, 64'h400, 64'h0, 1'b0));
    expect_issue(exe(2'd1, 3'd0, 7'd1, 64'h100b, 64'h0, 64'h300, 64'h0, 1'b0), 11);
    wb[11] = 1'b1;
    wait_drain(5, "t3_p");
    disp(info(2'd1, 3'd0, 7'd3, 7'd9, 7'd0, 64'h404, 64'h0, 1'b0));
    expect_issue(exe(2'd1, 3'd0, 7'd1, 64'h100d, 64'h0, 64'h304, 64'h0, 1'b0), 12);
    wb[13] = 1'b1;
    wait_drain(5, "t3_q");
    disp(info(2'd1, 3'd0, 7'd4, 7'd9, 7'd0, 64'h408, 64'h0, 1'b0));
    expect_issue(exe(2'd1, 3'd0, 7'd2, 64'h1009, 64'h0, 64'h400, 64'h0, 1'b0), 13);
    expect_issue(exe(2'd1, 3'd0, 7'd3, 64'h1009, 64'h0, 64'h404, 64'h0, 1'b0), 14);
    expect_issue(exe(2'd1, 3'd0, 7'd4, 64'h1009, 64'h0, 64'h408, 64'h0, 1'b0), 15);
    wb[9] = 1'b1;
    wait_drain(8, "t3_abc");
    expect_issue(exe(2'd1, 3'd0, 7'd1, 64'h100a, 64'h0, 64'h30c, 64'h0, 1'b0), 16);
    wb[10] = 1'b1;
    wait_drain(5, "t3_d");

    // backpressure: output frozen, queue fills, then drains back to back
    exe_ready = 1'b0;
    e0 = exe(2'd0, 3'd0, 7'd20, 64'h0, 64'h0, 64'h500, 64'h4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_issue(exe(2'd0, 3'd0, 7'(20 + k), 64'h0, 64'h0, 64'h500 + 64'(4 * k), 64'h4, 1'b0), 20 + k);
      disp(info(2'd0, 3'd0, 7'(20 + k), 7'd0, 7'd0, 64'h500 + 64'(4 * k), 64'h4, 1'b0));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("t4_stall_param", exe_param, e0);
      check("t4_stall_ready", disp_ready, 0);
    end
    step();
    exe_ready = 1'b1;
    repeat (5) step();
    check("t4_burst_left", exp_q.size(), 0);
    wait_drain(3, "t4_drain");

    // flush with a full queue and a same-cycle dispatch
    exe_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      disp(info(2'd0, 3'd0, 7'd30, 7'd0, 7'd0, 64'h600 + 64'(4 * k), 64'h0, 1'b0));
    flush      = 1'b1;
    disp_info  = info(2'd0, 3'd0, 7'd31, 7'd0, 7'd0, 64'h700, 64'h0, 1'b0);
    disp_valid = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    check("t5_occupancy", occupancy, 0);
    check("t5_exe_valid", exe_valid, 0);
    check("t5_disp_ready", disp_ready, 1);
    exe_ready = 1'b1;
    repeat (6) step();
    check("t5_quiet", exe_valid, 0);

    // reset in the middle of a stall
    exe_ready = 1'b0;
    disp(info(2'd0, 3'd0, 7'd40, 7'd0, 7'd0, 64'h800, 64'h0, 1'b0));
    disp(info(2'd0, 3'd0, 7'd41, 7'd0, 7'd0, 64'h804, 64'h0, 1'b0));
    check("t6_stalled_valid", exe_valid, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_exe_valid", exe_valid, 0);
    check("t6_exe_param", exe_param, 0);
    check("t6_disp_ready", disp_ready, 1);
    check("t6_occupancy", occupancy, 0);
    exe_ready = 1'b1;
    repeat (5) step();
    check("t6_quiet", exe_valid, 0);
    check("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jbr_issue.md
# jbr_issue

Parametrised jump/branch issue queue for the CrackCore backend: buffers up to `DP` JAL/JALR/BRANCH micro-ops from dispatch and wakes each on physical-register writeback. It selects the oldest ready entry through an age matrix and registers its operands towards the branch execute unit with a valid/ready handshake. It replaces the single-mode, no-backpressure jump issue stage and adds flush, stall handling and two-source readiness.

## Interface
- `DP`, 4, queue entries (≥2, power of two not required)
- `RB`, 2, rename bits per architectural register; physical tag width `TW = 5+RB`, PRF depth `PRF = 32<<RB`
- `XLEN`, 64, data/PC width
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush; discards queue and output register
- `disp_valid`  in  1  dispatch offers an op
- `disp_ready`  out  1  queue has a free entry
- `disp_info`  in  `JBR_INFO_DW`  {op[1:0], funct3[2:0], rd[TW], rs1[TW], rs2[TW], pc[XLEN], imm[XLEN], is_rvc}
- `wbLog_qout`  in  `PRF`  per-physical-register written-back flag
- `regFileX_read`  in  `XLEN*PRF`  flat physical register file
- `exe_valid`  out  1  output register holds an op
- `exe_ready`  in  1  branch unit accepts
- `exe_param`  out  `JBR_EXE_DW`  {op, funct3, rd, src1[XLEN], src2[XLEN], pc, imm, is_rvc}
- `occupancy`  out  `$clog2(DP+1)`  valid-entry count

## Operation
- op encoding: `JAL`=0, `JALR`=1, `BRANCH`=2; 3 is illegal, never allocated (push accepted but entry not marked valid).
- Alloc: `disp_valid & disp_ready` writes the lowest-index free entry; `disp_ready = ~&valid` (free slot from a same-cycle issue is not reused).
- Age matrix: on alloc of entry i, `older[i][j] <= valid[j]` for all j≠i; on any entry j freeing, column j clears.
- Ready per entry: JAL → 1; JALR → `wbLog_qout[rs1]`; BRANCH → `wbLog_qout[rs1] & wbLog_qout[rs2]`. Evaluated combinationally every cycle (same-cycle wakeup).
- Select: issue candidate = valid & ready entry with no valid & ready older entry; exactly one or none.
- Pop condition `adv = ~exe_valid | exe_ready`; on `adv` with candidate: entry freed, `exe_param` loaded with src1/src2 read from `regFileX_read` by tag (src2 = 0 for JAL/JALR), `exe_valid <= 1`. On `adv` without candidate: `exe_valid <= 0`.
- Stall (`exe_valid & ~exe_ready`): output register and queue frozen apart from allocation.
- `flush`: next cycle all valid bits, age matrix and `exe_valid` are 0; same-cycle dispatch is dropped and same-cycle issue discarded.
- Priority: `RST` > `flush` > issue/alloc (issue and alloc of different entries coexist in one cycle).

## Timing
- Reset: `exe_valid`=0, `exe_param`=0, `disp_ready`=1, `occupancy`=0, all valid bits and age bits 0.
- Dispatch at cycle t → entry valid t+1 → earliest `exe_valid` at t+2 (ready op, idle output).
- Back-to-back issue at one op per cycle while `exe_ready`=1.
- Full: `disp_ready`=0 while all DP valid; rises the cycle after an issue.
- `occupancy` is registered, reflects alloc/free of previous edge.

## Structure
- Package `jbr_pkg`: op enum, `JBR_INFO_DW`, `JBR_EXE_DW`, field offsets, info/exe packed structs as functions of RB/XLEN.
- Sub-module `age_mtx #(DP)`: alloc one-hot, free mask, request mask → oldest grant one-hot; holds the DP×DP matrix with synchronous clear.
- Top holds entry array, free-slot priority encoder, readiness logic, operand mux, output register.

## Test plan
- Reset then dispatch JAL pc=0x8000_0000 rd=5 → `exe_valid`=1 two cycles later, exe pc=0x8000_0000, src1=0, `occupancy` back to 0.
- Dispatch BRANCH(rs1=3,rs2=7) then JAL; wbLog[7]=0 → JAL issues first; set wbLog[7]=1 with reg7=0x55 → BRANCH issues next cycle with src2=0x55.
- Three ready JALR entries dispatched in order A,B,C into freed-hole slots → issue order A,B,C regardless of slot index.
- Hold `exe_ready`=0 for 5 cycles with DP=4 entries queued → `exe_param` stable, `disp_ready`=0; release → 4 issues in 4 consecutive cycles.
- Fill queue, assert `flush` together with `disp_valid` → next cycle `occupancy`=0, `exe_valid`=0, dropped op never issues.
- Assert `RST` mid-stall with `exe_valid`=1 → next cycle all outputs at reset values.
